// File: rtl/seg_scan_if.sv
// Bundle between the clock counter and the 7-segment scan driver.
// The counter side drives digits and set-mode selects; the driver returns the display bus.
interface seg_scan_if;
  logic [3:0] dig0;
  logic [3:0] dig1;
  logic [3:0] dig2;
  logic [3:0] dig3;
  logic [3:0] dig4;
  logic [3:0] dig5;
  logic       set_mode;
  logic       sel_hour;
  logic       sel_min;
  logic       sel_sec;
  logic [6:0] seg;
  logic [5:0] an;
  logic       dp;

  modport master (
    output dig0, dig1, dig2, dig3, dig4, dig5,
    output set_mode, sel_hour, sel_min, sel_sec,
    input  seg, an, dp
  );

  modport slave (
    input  dig0, dig1, dig2, dig3, dig4, dig5,
    input  set_mode, sel_hour, sel_min, sel_sec,
    output seg, an, dp
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed 7-segment driver for a 24h clock.
// Latches a per-frame digit snapshot, blinks the field being set, drives the colon DP
// and blanks the head of every slot to suppress ghosting. All outputs are registered.
module seg_scan_driver #(
  parameter int unsigned SLOT_TICKS  = 2,
  parameter int unsigned BLANK_TICKS = 0,
  parameter int unsigned BLINK_HALF  = 250
) (
  input logic       clk,
  input logic       rst,
  seg_scan_if.slave bus
);

  localparam int unsigned TickW  = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
  localparam int unsigned BlinkW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam bit          HasBlank = (BLANK_TICKS > 0);

  logic [TickW-1:0]  tick_q, tick_d;
  logic [2:0]        slot_q, slot_d;
  logic [5:0][3:0]   snap_q, snap_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_on_q, blink_on_d;
  logic              set_mode_q;
  logic [6:0]        seg_q, seg_d;
  logic [5:0]        an_q, an_d;
  logic              dp_q, dp_d;

  logic       tick_wrap;
  logic       frame_wrap;
  logic       set_rise;
  logic       blink_wrap;
  logic       field_hit;
  logic       blanked;
  logic [3:0] cur_dig;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;  // non-BCD codes show dark but keep the enable
    endcase
    return s;
  endfunction

  // Scan/blink next-state and registered output decode from current state.
  always_comb begin
    tick_wrap  = (tick_q == TickW'(SLOT_TICKS - 1));
    frame_wrap = tick_wrap && (slot_q == 3'd5);

    tick_d = tick_wrap ? '0 : tick_q + TickW'(1);
    slot_d = slot_q;
    if (tick_wrap) begin
      slot_d = (slot_q == 3'd5) ? 3'd0 : slot_q + 3'd1;
    end

    // Snapshot on the frame boundary so a frame never mixes old and new digits.
    snap_d = frame_wrap ? {bus.dig5, bus.dig4, bus.dig3, bus.dig2, bus.dig1, bus.dig0}
                        : snap_q;

    set_rise   = bus.set_mode && !set_mode_q;
    blink_wrap = (blink_cnt_q == BlinkW'(BLINK_HALF - 1));
    blink_cnt_d = blink_cnt_q + BlinkW'(1);
    blink_on_d  = blink_on_q;
    if (set_rise) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (blink_wrap) begin
      blink_cnt_d = '0;
      blink_on_d  = !blink_on_q;
    end

    case (slot_q)
      3'd0:    cur_dig = snap_q[0];
      3'd1:    cur_dig = snap_q[1];
      3'd2:    cur_dig = snap_q[2];
      3'd3:    cur_dig = snap_q[3];
      3'd4:    cur_dig = snap_q[4];
      3'd5:    cur_dig = snap_q[5];
      default: cur_dig = 4'd0;
    endcase

    field_hit = 1'b0;
    if (bus.set_mode) begin
      if (bus.sel_hour) begin
        field_hit = (slot_q == 3'd4) || (slot_q == 3'd5);
      end else if (bus.sel_min) begin
        field_hit = (slot_q == 3'd2) || (slot_q == 3'd3);
      end else if (bus.sel_sec) begin
        field_hit = (slot_q == 3'd0) || (slot_q == 3'd1);
      end
    end

    blanked = (HasBlank && (32'(tick_q) < BLANK_TICKS)) || (field_hit && !blink_on_q);

    seg_d = '0;
    an_d  = '0;
    dp_d  = 1'b0;
    if (!blanked) begin
      an_d  = 6'b000001 << slot_q;
      seg_d = decode(cur_dig);
      // Colon sits after hours and minutes; it flashes in run mode, steady while setting.
      dp_d  = ((slot_q == 3'd2) || (slot_q == 3'd4)) && (bus.set_mode || blink_on_q);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q      <= '0;
      slot_q      <= '0;
      snap_q      <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      set_mode_q  <= 1'b0;
      seg_q       <= '0;
      an_q        <= '0;
      dp_q        <= 1'b0;
    end else begin
      tick_q      <= tick_d;
      slot_q      <= slot_d;
      snap_q      <= snap_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      set_mode_q  <= bus.set_mode;
      seg_q       <= seg_d;
      an_q        <= an_d;
      dp_q        <= dp_d;
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;
  assign bus.dp  = dp_q;

endmodule
